spi_master_handover_seq: RTL and testbench

//  Sequences ownership handover of one SPI flash between the PFR CPLD and its host master (BMC or PCH).

---
 rtl/spi_master_handover_seq.sv | 180 ++++++++++++++++++
 tb/tb_spi_master_handover_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_handover_seq.sv
// SPI flash ownership handover sequencer.
// Moves one SPI flash between the PFR CPLD and its host master (BMC or PCH).
// The flash is always held in reset while the mux switches, and the command
// filter is updated before reset is released. One instance per flash.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a request, o_req_ready=1
// ST_RST_ASSERT | flash reset held low, mux not yet switched
// ST_SETTLE   | mux switched, waiting for the bus to settle
// ST_RELEASE  | filter updated, flash reset released on the next edge
// ST_DONE     | one-cycle o_done pulse (normal or aborted)
module spi_master_handover_seq #(
    parameter int RST_ASSERT_CYCLES = 16,
    parameter int SETTLE_CYCLES     = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_req_valid,
    input  logic i_req_tgt_pfr,
    input  logic i_req_hold_rst,
    output logic o_req_ready,
    input  logic i_abort,
    output logic o_master_sel_pfr,
    output logic o_flash_rst_n,
    output logic o_filter_disable,
    output logic o_busy,
    output logic o_done,
    output logic o_aborted
);

    localparam int CNT_MAX = (RST_ASSERT_CYCLES > SETTLE_CYCLES) ? RST_ASSERT_CYCLES
                                                                 : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RST_ASSERT = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;
    logic             hold_q, hold_d;
    logic             sel_q, sel_d;
    logic             rst_n_q, rst_n_d;
    logic             filt_dis_q, filt_dis_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    // State and output registers; reset leaves the PFR CPLD owning a flash held in reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tgt_q      <= 1'b1;
            hold_q     <= 1'b1;
            sel_q      <= 1'b1;
            rst_n_q    <= 1'b0;
            filt_dis_q <= 1'b1;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            hold_q     <= hold_d;
            sel_q      <= sel_d;
            rst_n_q    <= rst_n_d;
            filt_dis_q <= filt_dis_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output logic for the handover sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        hold_d     = hold_q;
        sel_d      = sel_q;
        rst_n_d    = rst_n_q;
        filt_dis_d = filt_dis_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    tgt_d      = i_req_tgt_pfr;
                    hold_d     = i_req_hold_rst;
                    cnt_d      = '0;
                    rst_n_d    = 1'b0;
                    filt_dis_d = 1'b1;
                    state_d    = ST_RST_ASSERT;
                end
            end
            ST_RST_ASSERT: begin
                if (i_abort) begin
                    // Abort beats the mux switch on the same edge.
                    rst_n_d    = 1'b0;
                    filt_dis_d = 1'b1;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                end else if (cnt_q == RST_LAST) begin
                    sel_d   = tgt_q;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (i_abort) begin
                    rst_n_d    = 1'b0;
                    filt_dis_d = 1'b1;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                end else if (cnt_q == SETTLE_LAST) begin
                    // Filter stays enabled only when the host owns the flash.
                    filt_dis_d = tgt_q;
                    cnt_d      = '0;
                    state_d    = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (i_abort) begin
                    rst_n_d    = 1'b0;
                    filt_dis_d = 1'b1;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                end else begin
                    rst_n_d = !hold_q;
                    done_d  = 1'b1;
                end
                cnt_d   = '0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    assign o_req_ready      = ready_q;
    assign o_busy           = busy_q;
    assign o_master_sel_pfr = sel_q;
    assign o_flash_rst_n    = rst_n_q;
    assign o_filter_disable = filt_dis_q;
    assign o_done           = done_q;
    assign o_aborted        = aborted_q;

endmodule

// File: tb/tb_spi_master_handover_seq.sv
// Self-checking bench for spi_master_handover_seq.
module tb_spi_master_handover_seq;

    localparam int R = 16;
    localparam int S = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic i_req_valid = 1'b0;
    logic i_req_tgt_pfr = 1'b0;
    logic i_req_hold_rst = 1'b0;
    logic i_abort = 1'b0;
    logic o_req_ready, o_master_sel_pfr, o_flash_rst_n, o_filter_disable;
    logic o_busy, o_done, o_aborted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic sel;
        logic rst_n;
        logic filt;
        logic aborted;
        int   k;
    } exp_t;

    exp_t sb[$];

    // bench model of the static outputs between sequences
    logic sel_m, rstn_m, filt_m;

    always #5 clk = ~clk;

    spi_master_handover_seq #(
        .RST_ASSERT_CYCLES(R),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .i_req_valid(i_req_valid),
        .i_req_tgt_pfr(i_req_tgt_pfr),
        .i_req_hold_rst(i_req_hold_rst),
        .o_req_ready(o_req_ready),
        .i_abort(i_abort),
        .o_master_sel_pfr(o_master_sel_pfr),
        .o_flash_rst_n(o_flash_rst_n),
        .o_filter_disable(o_filter_disable),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_aborted(o_aborted)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [5:0] got;
        resetn = 1'b0;
        i_req_valid = 1'b0;
        i_abort = 1'b0;
        repeat (3) @(negedge clk);
        got = {o_master_sel_pfr, o_flash_rst_n, o_filter_disable, o_req_ready, o_busy, o_done};
        checks++;
        if (got !== 6'b101100) begin
            errors++;
            $display("FAIL reset_held got=%b exp=101100", got);
        end
        resetn = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            got = {o_master_sel_pfr, o_flash_rst_n, o_filter_disable, o_req_ready, o_busy, o_done};
            checks++;
            if (got !== 6'b101100) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=101100", c, got);
            end
        end
        sel_m  = 1'b1;
        rstn_m = 1'b0;
        filt_m = 1'b1;
    endtask

    // One handover; abort_at>0 aborts at edge E0+abort_at, pulse_at>=0 pulses a
    // conflicting request for two cycles while busy.
    task automatic test_handover(input string name, input logic tgt, input logic hold,
                                 input int abort_at, input int pulse_at);
        int   waitc;
        int   last_k;
        int   done_k;
        logic ab;
        logic sel0;
        logic sel_e, rstn_e, filt_e, done_e, ready_e;
        logic [5:0] got, exp;
        exp_t e;

        waitc = 0;
        while (o_req_ready !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout got=%b exp=1", name, o_req_ready);
            return;
        end

        i_req_valid    = 1'b1;
        i_req_tgt_pfr  = tgt;
        i_req_hold_rst = hold;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;

        ab     = (abort_at > 0);
        sel0   = sel_m;
        done_k = ab ? abort_at : R + S + 1;
        last_k = done_k + 1;

        e.sel     = ab ? ((abort_at > R) ? tgt : sel0) : tgt;
        e.rst_n   = ab ? 1'b0 : !hold;
        e.filt    = ab ? 1'b1 : tgt;
        e.aborted = ab;
        e.k       = done_k;
        sb.push_back(e);

        for (int k = 0; k <= last_k; k++) begin
            if (ab && k >= abort_at) begin
                sel_e   = (abort_at > R) ? tgt : sel0;
                rstn_e  = 1'b0;
                filt_e  = 1'b1;
                done_e  = (k == abort_at);
                ready_e = (k > abort_at);
            end else begin
                sel_e   = (k >= R) ? tgt : sel0;
                filt_e  = (k >= R + S) ? tgt : 1'b1;
                rstn_e  = (k >= R + S + 1) ? !hold : 1'b0;
                done_e  = (k == R + S + 1);
                ready_e = (k >= R + S + 2);
            end
            exp = {sel_e, rstn_e, filt_e, done_e, ready_e, !ready_e};
            got = {o_master_sel_pfr, o_flash_rst_n, o_filter_disable, o_done, o_req_ready, o_busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_cycle k=%0d sel/rstn/filt/done/ready/busy got=%b exp=%b",
                         name, k, got, exp);
            end

            if (o_done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected_done k=%0d got=1 exp=0", name, k);
                end else begin
                    e = sb.pop_front();
                    got = {o_master_sel_pfr, o_flash_rst_n, o_filter_disable, o_aborted, 2'b00};
                    exp = {e.sel, e.rst_n, e.filt, e.aborted, 2'b00};
                    if (got !== exp || k != e.k) begin
                        errors++;
                        $display("FAIL %s_done_result k=%0d sel/rstn/filt/aborted got=%b exp=%b exp_k=%0d",
                                 name, k, got[5:2], exp[5:2], e.k);
                    end
                end
            end

            i_abort = ab && (k == abort_at - 1);
            if (pulse_at >= 0 && k >= pulse_at && k < pulse_at + 2) begin
                i_req_valid    = 1'b1;
                i_req_tgt_pfr  = !tgt;
                i_req_hold_rst = !hold;
            end else begin
                i_req_valid    = 1'b0;
                i_req_tgt_pfr  = !tgt;
                i_req_hold_rst = !hold;
            end
            if (k < last_k) @(negedge clk);
        end
        i_abort     = 1'b0;
        i_req_valid = 1'b0;

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_done_missing got=%0d pending exp=0", name, sb.size());
        end
        sb.delete();

        sel_m  = e.sel;
        rstn_m = ab ? 1'b0 : !hold;
        filt_m = ab ? 1'b1 : tgt;
    endtask

    task automatic test_back_to_back();
        logic [5:0] got, exp;
        test_handover("b2b_pulse", 1'b1, 1'b0, 0, 3);
        test_handover("b2b_next", 1'b0, 1'b1, 0, -1);
        // idle with abort asserted and no request: nothing may change
        for (int c = 0; c < 10; c++) begin
            i_abort = c[0];
            @(negedge clk);
            exp = {sel_m, rstn_m, filt_m, 1'b0, 1'b1, 1'b0};
            got = {o_master_sel_pfr, o_flash_rst_n, o_filter_disable, o_done, o_req_ready, o_busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL idle_abort_ignored c=%0d got=%b exp=%b", c, got, exp);
            end
        end
        i_abort = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [5:0] got, exp;
        exp_t e;
        @(negedge clk);
        i_req_valid    = 1'b1;
        i_req_tgt_pfr  = 1'b1;
        i_req_hold_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        e.sel = 1'b1; e.rst_n = 1'b1; e.filt = 1'b1; e.aborted = 1'b0; e.k = R + S + 1;
        sb.push_back(e);
        for (int k = 1; k < 10; k++) begin
            i_req_valid   = (k == 3 || k == 4);
            i_req_tgt_pfr = 1'b0;
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_master_sel_pfr !== sel_m) begin
            errors++;
            $display("FAIL arst_pre busy/sel got=%b%b exp=1%b", o_busy, o_master_sel_pfr, sel_m);
        end
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        exp = 6'b101100;
        got = {o_master_sel_pfr, o_flash_rst_n, o_filter_disable, o_req_ready, o_busy, o_done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL arst_immediate got=%b exp=%b", got, exp);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            got = {o_master_sel_pfr, o_flash_rst_n, o_filter_disable, o_req_ready, o_busy, o_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL arst_stays_idle c=%0d got=%b exp=%b", c, got, exp);
            end
        end
        sel_m  = 1'b1;
        rstn_m = 1'b0;
        filt_m = 1'b1;
    endtask

    initial begin
        test_reset();
        test_handover("to_host", 1'b0, 1'b0, 0, -1);
        test_handover("to_pfr_hold", 1'b1, 1'b1, 0, -1);
        test_handover("abort5", 1'b0, 1'b0, 5, -1);
        test_handover("abort_at_switch", 1'b0, 1'b0, R, -1);
        test_handover("abort20", 1'b0, 1'b0, 20, -1);
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
